btn_conditioner: RTL and testbench

BTN_CONDITIONER -- requirements
Module: btn_conditioner

---
 rtl/vga_game_pkg.sv | 19 +
 rtl/debounce_fsm.sv | 118 +++++++++++
 rtl/btn_conditioner.sv | 44 ++++
 tb/tb_btn_conditioner.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/vga_game_pkg.sv
// Shared definitions for the game front end: button bit positions,
// debounce FSM state encoding and the default debounce interval.
package vga_game_pkg;

  localparam int BTN_LEFT  = 0;
  localparam int BTN_RIGHT = 1;
  localparam int BTN_JUMP  = 2;

  // 10 ms at 100 MHz
  localparam int DEBOUNCE_CYCLES_DEF = 1000000;

  typedef enum logic [1:0] {
    DB_IDLE        = 2'd0,
    DB_ARM_PRESS   = 2'd1,
    DB_PRESSED     = 2'd2,
    DB_ARM_RELEASE = 2'd3
  } db_state_e;

endpackage

// File: rtl/debounce_fsm.sv
// Single-button conditioner: 2-flop synchronizer, debounce FSM with a
// stable-time counter, and registered level / press / release outputs.
//
// state          | meaning
// ---------------+---------------------------------------------------
// DB_IDLE        | released and stable, waiting for sync=1
// DB_ARM_PRESS   | sync=1 seen, counting stable-high cycles
// DB_PRESSED     | pressed and stable, waiting for sync=0
// DB_ARM_RELEASE | sync=0 seen, counting stable-low cycles
module debounce_fsm
  import vga_game_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_W           = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q, sync_d;
  logic             sync;
  db_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic             release_q, release_d;

  assign sync = sync_q[1];

  // Shift the raw input into the two-stage synchronizer.
  always_comb begin
    sync_d = {sync_q[0], btn_raw};
  end

  // Synchronizer flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= sync_d;
  end

  // Next-state, counter and output logic; outputs follow the next state so
  // the level and its edge pulse land on the same edge as the transition.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      DB_IDLE: begin
        if (sync) begin
          state_d = DB_ARM_PRESS;
          cnt_d   = '0;
        end
      end
      DB_ARM_PRESS: begin
        if (!sync) begin
          state_d = DB_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d = DB_PRESSED;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DB_PRESSED: begin
        if (!sync) begin
          state_d = DB_ARM_RELEASE;
          cnt_d   = '0;
        end
      end
      DB_ARM_RELEASE: begin
        if (sync) begin
          state_d = DB_PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d = DB_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = DB_IDLE;
        cnt_d   = '0;
      end
    endcase
    level_d   = (state_d == DB_PRESSED) || (state_d == DB_ARM_RELEASE);
    press_d   = level_d & ~level_q;
    release_d = ~level_d & level_q;
  end

  // FSM state, counter and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= DB_IDLE;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign btn_level   = level_q;
  assign btn_press   = press_q;
  assign btn_release = release_q;

endmodule

// File: rtl/btn_conditioner.sv
// Debounces the three game push-buttons (left, right, jump) independently;
// no arbitration between bits.
module btn_conditioner
  import vga_game_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_W           = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] btn_raw,
  output logic [2:0] btn_level,
  output logic [2:0] btn_press,
  output logic [2:0] btn_release
);

  debounce_fsm #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_left (
    .clk         (clk),
    .rst         (rst),
    .btn_raw     (btn_raw[BTN_LEFT]),
    .btn_level   (btn_level[BTN_LEFT]),
    .btn_press   (btn_press[BTN_LEFT]),
    .btn_release (btn_release[BTN_LEFT])
  );

  debounce_fsm #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_right (
    .clk         (clk),
    .rst         (rst),
    .btn_raw     (btn_raw[BTN_RIGHT]),
    .btn_level   (btn_level[BTN_RIGHT]),
    .btn_press   (btn_press[BTN_RIGHT]),
    .btn_release (btn_release[BTN_RIGHT])
  );

  debounce_fsm #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_jump (
    .clk         (clk),
    .rst         (rst),
    .btn_raw     (btn_raw[BTN_JUMP]),
    .btn_level   (btn_level[BTN_JUMP]),
    .btn_press   (btn_press[BTN_JUMP]),
    .btn_release (btn_release[BTN_JUMP])
  );

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner with DEBOUNCE_CYCLES=4, CNT_W=2.
// A change first sampled at edge k shows on the outputs after edge k+6.
module tb_btn_conditioner;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] btn_raw = 3'b000;
  logic [2:0] btn_level, btn_press, btn_release;

  int n_tests = 0;
  int n_fail  = 0;
  int press_cnt [3];
  int rel_cnt   [3];

  btn_conditioner #(.DEBOUNCE_CYCLES(4), .CNT_W(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .btn_raw     (btn_raw),
    .btn_level   (btn_level),
    .btn_press   (btn_press),
    .btn_release (btn_release)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // advance n rising edges, landing 1 time unit after the last one
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clr_cnt();
    for (int i = 0; i < 3; i++) begin
      press_cnt[i] = 0;
      rel_cnt[i]   = 0;
    end
  endtask

  task automatic chk_out(input string tag, input logic [2:0] lvl,
                         input logic [2:0] prs, input logic [2:0] rel);
    chk({tag, "_level"},   {29'd0, btn_level},   {29'd0, lvl});
    chk({tag, "_press"},   {29'd0, btn_press},   {29'd0, prs});
    chk({tag, "_release"}, {29'd0, btn_release}, {29'd0, rel});
  endtask

  // pulse counting and press/release exclusivity on every cycle
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (btn_press[i])   press_cnt[i]++;
      if (btn_release[i]) rel_cnt[i]++;
    end
    chk("press_release_excl", {29'd0, btn_press & btn_release}, 32'd0);
  end

  initial begin
    clr_cnt();
    #1;
    chk_out("rst_async", 3'b000, 3'b000, 3'b000);
    step(3);
    chk_out("rst_held", 3'b000, 3'b000, 3'b000);
    rst = 1'b0;
    step(2);
    chk_out("idle", 3'b000, 3'b000, 3'b000);

    // clean press on left
    clr_cnt();
    btn_raw = 3'b001;
    step(6);
    chk_out("clean_e6", 3'b000, 3'b000, 3'b000);
    step(1);
    chk_out("clean_e7", 3'b001, 3'b001, 3'b000);
    step(1);
    chk_out("clean_e8", 3'b001, 3'b000, 3'b000);
    // clean release on left
    btn_raw = 3'b000;
    step(6);
    chk_out("crel_e6", 3'b001, 3'b000, 3'b000);
    step(1);
    chk_out("crel_e7", 3'b000, 3'b000, 3'b001);
    step(1);
    chk_out("crel_e8", 3'b000, 3'b000, 3'b000);
    chk("clean_press_cnt0", press_cnt[0], 1);
    chk("clean_rel_cnt0", rel_cnt[0], 1);
    chk("clean_press_cnt1", press_cnt[1], 0);
    chk("clean_press_cnt2", press_cnt[2], 0);

    // bounce on jump: 1,1,0,0 x5, then held high
    clr_cnt();
    for (int i = 0; i < 20; i++) begin
      btn_raw = (i % 4 < 2) ? 3'b100 : 3'b000;
      step(1);
      chk("bounce_level", {29'd0, btn_level}, 32'd0);
    end
    chk("bounce_press_cnt", press_cnt[2], 0);
    btn_raw = 3'b100;
    step(6);
    chk_out("bounce_e6", 3'b000, 3'b000, 3'b000);
    step(1);
    chk_out("bounce_e7", 3'b100, 3'b100, 3'b000);
    step(3);
    chk("bounce_one_press", press_cnt[2], 1);
    btn_raw = 3'b000;
    step(8);
    chk("bounce_released", {29'd0, btn_level}, 32'd0);

    // release with glitch on right
    btn_raw = 3'b010;
    step(8);
    chk("glitch_pressed", {29'd0, btn_level}, 32'd2);
    clr_cnt();
    btn_raw = 3'b000;
    step(3);
    btn_raw = 3'b010;
    for (int i = 0; i < 10; i++) begin
      step(1);
      chk("glitch_hold_level", {29'd0, btn_level}, 32'd2);
    end
    chk("glitch_no_rel", rel_cnt[1], 0);
    chk("glitch_no_press", press_cnt[1], 0);
    btn_raw = 3'b000;
    step(6);
    chk_out("grel_e6", 3'b010, 3'b000, 3'b000);
    step(1);
    chk_out("grel_e7", 3'b000, 3'b000, 3'b010);
    step(2);
    chk("grel_one_rel", rel_cnt[1], 1);
    chk("grel_no_press", press_cnt[1], 0);

    // async reset while pressed: clears without a clock edge
    btn_raw = 3'b001;
    step(8);
    chk("ar_pressed", {29'd0, btn_level}, 32'd1);
    clr_cnt();
    #2 rst = 1'b1;
    #1;
    chk_out("ar_async_clear", 3'b000, 3'b000, 3'b000);
    #1 rst = 1'b0;
    step(6);
    chk_out("ar_fresh_e6", 3'b000, 3'b000, 3'b000);
    step(1);
    chk_out("ar_fresh_e7", 3'b001, 3'b001, 3'b000);
    step(1);
    chk("ar_fresh_press_cnt", press_cnt[0], 1);
    chk("ar_no_release", rel_cnt[0], 0);

    // async reset mid ARM_PRESS discards the partial count
    btn_raw = 3'b000;
    step(8);
    clr_cnt();
    btn_raw = 3'b001;
    step(4);
    #2 rst = 1'b1;
    #1;
    chk_out("ar_mid_clear", 3'b000, 3'b000, 3'b000);
    #1 rst = 1'b0;
    step(6);
    chk_out("ar_mid_e6", 3'b000, 3'b000, 3'b000);
    step(1);
    chk_out("ar_mid_e7", 3'b001, 3'b001, 3'b000);
    step(2);
    chk("ar_mid_press_cnt", press_cnt[0], 1);
    btn_raw = 3'b000;
    step(8);
    chk("ar_mid_released", {29'd0, btn_level}, 32'd0);

    // simultaneous press on all three
    clr_cnt();
    btn_raw = 3'b111;
    step(6);
    chk_out("sim_e6", 3'b000, 3'b000, 3'b000);
    step(1);
    chk_out("sim_e7", 3'b111, 3'b111, 3'b000);
    step(1);
    chk_out("sim_e8", 3'b111, 3'b000, 3'b000);
    btn_raw = 3'b000;
    step(7);
    chk_out("sim_rel_e7", 3'b000, 3'b000, 3'b111);
    step(2);
    for (int i = 0; i < 3; i++) begin
      chk("sim_press_cnt", press_cnt[i], 1);
      chk("sim_rel_cnt", rel_cnt[i], 1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
